bus_memory: RTL and testbench
=============================

Name: bus_memory

Overview:
- Bus responder for the CPU's single-master memory interface: word-addressed RAM plus a small memory-mapped I/O page.
- Sits on the other end of the CPU's address/datao/rw/data bus; `rw`=1 is a write, `rw`=0 is a read.
- The MMIO page provides a byte output FIFO drained through a valid/ready port, a status register and a free-running cycle counter.
- A side load port preloads programs from the testbench.

Parameters:
- AW, 10, RAM address width; RAM holds 2^AW 32-bit words.
- FIFO_AW, 3, output FIFO address width; depth is 2^FIFO_AW entries.
- MMIO_BASE, 32'hFFFF_FF00, base address of the I/O page.

Ports:
- clock  input  1  system clock; all state updates on its rising edge
- reset  input  1  synchronous, active-high reset
- address  input  32  word address from the CPU
- datao  input  32  write data from the CPU
- rw  input  1  1 = write this cycle, 0 = read
- data  output  32  registered read data to the CPU
- load_en  input  1  preload write strobe
- load_addr  input  AW  preload word index
- load_data  input  32  preload word
- out_data  output  8  FIFO head byte
- out_valid  output  1  FIFO non-empty
- out_ready  input  1  consumer accepts head byte this cycle

Behaviour:
- Interface (already decided): one clock, `clock`; `reset` is synchronous and active-high.
- Reset values:
  - data=0, out_valid=0, out_data=0.
  - FIFO pointers and count = 0.
  - Cycle counter = 0; sticky error bits = 0.
  - RAM contents are not reset.
- Decode:
  - RAM hit when address < 2^AW; word index = address[AW-1:0].
  - MMIO hit when address[31:8] == MMIO_BASE[31:8].
  - Any other address is unmapped.
- Read path, fixed 1-cycle latency:
  - `data` after edge N reflects the address presented before edge N.
  - Every cycle performs a read, including write cycles; a write cycle's read returns the old contents (read-before-write).
- RAM write: rw=1 and RAM hit → word written at the edge.
- load_en=1 writes load_data at load_addr.
  - If a CPU RAM write and load_en occur in the same cycle, load wins and the CPU write is dropped.
  - load_en is independent of rw and of the address decode.
- MMIO registers (offsets from MMIO_BASE):
  - +0x00 OUT:
    - Write pushes datao[7:0] into the FIFO.
    - Read returns 0.
  - +0x04 STATUS (read):
    - bit0 full, bit1 empty, bit2 unmapped-access sticky, bit3 overflow sticky.
    - bits[11:8] = count.
    - All other bits 0.
    - A write (any data) clears bits 2 and 3.
  - +0x08 CYCLES (read):
    - Counter increments every cycle and wraps 0xFFFF_FFFF → 0.
    - A write makes it read 0 on the next cycle, then count up.
  - Other MMIO offsets behave as unmapped.
- Unmapped access (read or write):
  - Write has no effect; read returns 0.
  - Sets the bit2 sticky.
- FIFO:
  - Registered, no fall-through: a push into an empty FIFO raises out_valid on the next cycle.
  - out_data = head byte while out_valid=1.
  - Pop when out_valid & out_ready.
  - Push when full without a simultaneous pop: byte dropped, bit3 sticky set, count unchanged.
  - Push and pop in the same cycle when full: both occur, count stays at max, no overflow.
  - Push and pop in the same cycle otherwise: count unchanged.
  - Pointers wrap modulo 2^FIFO_AW.
  - count ranges 0..2^FIFO_AW; full = (count == 2^FIFO_AW).
- Reset while FIFO non-empty or mid-transfer:
  - FIFO emptied, out_valid=0 after the edge.
  - Queued bytes are lost; no partial state is retained.
- rw sampled X/1 during reset is ignored; reset dominates every write source, including load_en.

Test Plan:
- Preload + read:
  - Stimulus: load_en writes 0x1234_5678 at index 5; then present address=5 with rw=0.
  - Required: data=0x1234_5678 exactly one cycle later.
  - Repeat with address=0x405 (AW=10): required data=0 and STATUS bit2=1.
- CPU write with read-before-write:
  - Stimulus: word 7 holds 0xAAAA_AAAA; write 0x5555_5555 to address 7 with rw=1; then read address 7.
  - Required: data=0xAAAA_AAAA on the cycle after the write, 0x5555_5555 on the cycle after the read.
  - Load-priority check: load_en to index 7 in the same cycle as the CPU write → load value stored.
- FIFO fill/overflow:
  - Stimulus: out_ready=0; write bytes 0x41..0x49 (9 writes) to MMIO_BASE+0.
  - Required: STATUS reads count=8, full=1, bit3=1.
  - Then: out_ready=1; required out_data sequence 0x41..0x48, then out_valid=0 and STATUS empty=1.
  - Then: write STATUS; required bit3=0.
- Push+pop when full:
  - Stimulus: FIFO full with out_ready=1; push 0x5A in the same cycle.
  - Required: count stays 8, no overflow, and 0x5A emerges after the 7 remaining older bytes.
- Cycle counter:
  - Stimulus: read CYCLES on two consecutive cycles; then write CYCLES and read it on the next cycle.
  - Required: the two consecutive reads differ by 1; the post-write read returns 0, then 1.
  - Wrap check: force the counter to 0xFFFF_FFFF; required next read = 0.
- Reset mid-operation:
  - Stimulus: FIFO holds 3 bytes, STATUS bit2=1; assert reset for 1 cycle.
  - Required: after reset out_valid=0, data=0, STATUS=0x0000_0002, CYCLES restarts from 0, and RAM word 5 still holds 0x1234_5678.

Source files
------------

// File: rtl/bus_memory.sv
// Bus responder for the CPU memory interface: word-addressed RAM plus an MMIO page
// holding a byte output FIFO, a status register and a free-running cycle counter.
module bus_memory #(
    parameter int unsigned AW        = 10,
    parameter int unsigned FIFO_AW   = 3,
    parameter logic [31:0] MMIO_BASE = 32'hFFFF_FF00
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [31:0]   address,
    input  logic [31:0]   datao,
    input  logic          rw,
    output logic [31:0]   data,
    input  logic          load_en,
    input  logic [AW-1:0] load_addr,
    input  logic [31:0]   load_data,
    output logic [7:0]    out_data,
    output logic          out_valid,
    input  logic          out_ready
);

    localparam int unsigned DEPTH      = 2 ** FIFO_AW;
    localparam int unsigned CW         = FIFO_AW + 1;
    localparam int unsigned RAM_WORDS  = 2 ** AW;
    localparam logic [7:0]  OFF_OUT    = 8'h00;
    localparam logic [7:0]  OFF_STATUS = 8'h04;
    localparam logic [7:0]  OFF_CYCLES = 8'h08;

    logic [31:0]        mem [RAM_WORDS];
    logic [7:0]         fifo [DEPTH];

    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [CW-1:0]      count;
    logic [31:0]        cycles;
    logic               unm_sticky;
    logic               ovf_sticky;

    logic               ram_hit;
    logic               mmio_hit;
    logic               sel_out;
    logic               sel_status;
    logic               sel_cycles;
    logic               unmapped;
    logic [AW-1:0]      idx;
    logic               full;
    logic               empty;
    logic               pop;
    logic               push_req;
    logic               push;
    logic               overflow;
    logic [31:0]        status;
    logic [31:0]        rd_data;
    logic [CW-1:0]      count_next;
    logic [FIFO_AW-1:0] rd_next;
    logic [7:0]         head_next;
    logic               ram_we;
    logic [AW-1:0]      ram_wa;
    logic [31:0]        ram_wd;

    // Address decode, FIFO handshake and read-data mux
    always_comb begin
        ram_hit    = (address[31:AW] == '0);
        mmio_hit   = (address[31:8] == MMIO_BASE[31:8]);
        idx        = address[AW-1:0];
        sel_out    = mmio_hit && (address[7:0] == OFF_OUT);
        sel_status = mmio_hit && (address[7:0] == OFF_STATUS);
        sel_cycles = mmio_hit && (address[7:0] == OFF_CYCLES);
        unmapped   = !ram_hit && !sel_out && !sel_status && !sel_cycles;

        full     = (count == CW'(DEPTH));
        empty    = (count == '0);
        pop      = out_valid && out_ready;
        push_req = rw && sel_out;
        // A full FIFO still accepts a byte when the head leaves in the same cycle
        push     = push_req && (!full || pop);
        overflow = push_req && full && !pop;

        status           = '0;
        status[0]        = full;
        status[1]        = empty;
        status[2]        = unm_sticky;
        status[3]        = ovf_sticky;
        status[8 +: CW]  = count;

        rd_data = '0;
        if (ram_hit) begin
            rd_data = mem[idx];
        end else if (sel_status) begin
            rd_data = status;
        end else if (sel_cycles) begin
            rd_data = cycles;
        end

        count_next = count + CW'(push) - CW'(pop);
        rd_next    = pop ? rd_ptr + FIFO_AW'(1) : rd_ptr;
        // New head may be the byte being pushed this cycle (empty, or single entry leaving)
        head_next  = (push && (wr_ptr == rd_next)) ? datao[7:0] : fifo[rd_next];

        ram_we = !reset && (load_en || (rw && ram_hit));
        ram_wa = load_en ? load_addr : idx;
        ram_wd = load_en ? load_data : datao;
    end

    // RAM storage, not reset; preload port overrides a concurrent CPU write
    always_ff @(posedge clock) begin
        if (ram_we) begin
            mem[ram_wa] <= ram_wd;
        end
    end

    // FIFO storage
    always_ff @(posedge clock) begin
        if (!reset && push) begin
            fifo[wr_ptr] <= datao[7:0];
        end
    end

    // Control state, read register and output port
    always_ff @(posedge clock) begin
        if (reset) begin
            data       <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            cycles     <= '0;
            unm_sticky <= 1'b0;
            ovf_sticky <= 1'b0;
        end else begin
            data      <= rd_data;
            wr_ptr    <= push ? wr_ptr + FIFO_AW'(1) : wr_ptr;
            rd_ptr    <= rd_next;
            count     <= count_next;
            out_valid <= (count_next != '0);
            out_data  <= (count_next != '0) ? head_next : 8'h00;
            cycles    <= (rw && sel_cycles) ? 32'd0 : cycles + 32'd1;

            if (rw && sel_status) begin
                unm_sticky <= 1'b0;
                ovf_sticky <= 1'b0;
            end else begin
                if (unmapped) begin
                    unm_sticky <= 1'b1;
                end
                if (overflow) begin
                    ovf_sticky <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_bus_memory.sv
// Self-checking bench for bus_memory: directed vector table, multi-cycle corner
// sequences and a randomized phase against a queue/array reference model.
module tb_bus_memory;

    localparam int unsigned AW      = 10;
    localparam logic [31:0] MM_OUT  = 32'hFFFF_FF00;
    localparam logic [31:0] MM_ST   = 32'hFFFF_FF04;
    localparam logic [31:0] MM_CYC  = 32'hFFFF_FF08;
    localparam logic [31:0] MM_BAD  = 32'hFFFF_FF0C;
    localparam logic [31:0] UNMAP   = 32'h0000_0405;

    logic          clock;
    logic          reset;
    logic [31:0]   address;
    logic [31:0]   datao;
    logic          rw;
    logic [31:0]   data;
    logic          load_en;
    logic [AW-1:0] load_addr;
    logic [31:0]   load_data;
    logic [7:0]    out_data;
    logic          out_valid;
    logic          out_ready;

    bus_memory #(.AW(AW), .FIFO_AW(3), .MMIO_BASE(32'hFFFF_FF00)) dut (
        .clock     (clock),
        .reset     (reset),
        .address   (address),
        .datao     (datao),
        .rw        (rw),
        .data      (data),
        .load_en   (load_en),
        .load_addr (load_addr),
        .load_data (load_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;

    // Reference model state
    logic [31:0] m_ram [1024];
    bit          m_known [1024];
    logic [7:0]  m_q [$];
    bit          m_unm, m_ovf, m_cyc_ok;
    logic [31:0] m_cyc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_step(output logic [31:0] e, output bit c);
        bit ram_hit, mm, unm, pop, push, was_full;
        logic [7:0] off;
        e = 32'h0;
        c = 1'b1;
        if (reset) begin
            m_q.delete();
            m_unm = 0; m_ovf = 0; m_cyc = 32'h0; m_cyc_ok = 1;
            return;
        end
        ram_hit = (address < 32'd1024);
        mm      = (address[31:8] == 24'hFF_FFFF);
        off     = address[7:0];
        unm     = !ram_hit && !(mm && (off == 8'h00 || off == 8'h04 || off == 8'h08));
        if (ram_hit) begin
            e = m_ram[address[9:0]];
            c = m_known[address[9:0]];
        end else if (mm && off == 8'h04) begin
            e = (32'(m_q.size()) << 8) | {28'h0, m_ovf, m_unm, m_q.size() == 0, m_q.size() == 8};
        end else if (mm && off == 8'h08) begin
            e = m_cyc;
            c = m_cyc_ok;
        end
        if (unm) m_unm = 1;
        if (rw && mm && off == 8'h04) begin
            m_unm = 0; m_ovf = 0;
        end
        was_full = (m_q.size() == 8);
        pop  = (m_q.size() != 0) && out_ready;
        push = rw && mm && off == 8'h00;
        if (pop) void'(m_q.pop_front());
        if (push) begin
            if (was_full && !pop) m_ovf = 1;
            else m_q.push_back(datao[7:0]);
        end
        if (load_en) begin
            m_ram[load_addr] = load_data;
            m_known[load_addr] = 1;
        end else if (rw && ram_hit) begin
            m_ram[address[9:0]] = datao;
            m_known[address[9:0]] = 1;
        end
        if (rw && mm && off == 8'h08) begin
            m_cyc = 32'h0; m_cyc_ok = 1;
        end else begin
            m_cyc = m_cyc + 32'd1;
        end
    endfunction

    // One clock: predict, step, then compare outputs 1 time unit after the edge
    task automatic cycle();
        logic [31:0] exp_d;
        bit chk_d;
        model_step(exp_d, chk_d);
        @(posedge clock);
        #1;
        if (chk_d) check("model_data", data, exp_d);
        check("model_out_valid", 32'(out_valid), 32'(m_q.size() != 0));
        if (m_q.size() != 0) check("model_out_data", 32'(out_data), 32'(m_q[0]));
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic w);
        address = a;
        datao   = d;
        rw      = w;
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        wr;
        logic        ld;
        logic [9:0]  ld_addr;
        logic [31:0] ld_data;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [11];
    logic [31:0] d1, d2;
    logic [7:0]  exp_seq [8];
    bit          got;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 1024; i++) m_known[i] = 0;
        m_unm = 0; m_ovf = 0; m_cyc = 0; m_cyc_ok = 1;
        reset = 1'b1; address = 32'h0; datao = 32'h0; rw = 1'b0;
        load_en = 1'b0; load_addr = '0; load_data = 32'h0; out_ready = 1'b0;

        cycle();
        cycle();
        reset = 1'b0;
        check("reset_data", data, 32'h0);
        check("reset_out_valid", 32'(out_valid), 32'h0);
        check("reset_out_data", 32'(out_data), 32'h0);

        // Directed vectors: {addr, wdata, rw, load_en, load_addr, load_data, expected data}
        vecs[0]  = '{MM_ST, 32'h0,         1'b0, 1'b1, 10'd0, 32'h0,         32'h0000_0002};
        vecs[1]  = '{MM_ST, 32'h0,         1'b0, 1'b1, 10'd5, 32'h1234_5678, 32'h0000_0002};
        vecs[2]  = '{32'd5, 32'h0,         1'b0, 1'b0, 10'd0, 32'h0,         32'h1234_5678};
        vecs[3]  = '{UNMAP, 32'h0,         1'b0, 1'b0, 10'd0, 32'h0,         32'h0};
        vecs[4]  = '{MM_ST, 32'h0,         1'b0, 1'b0, 10'd0, 32'h0,         32'h0000_0006};
        vecs[5]  = '{MM_ST, 32'h0,         1'b1, 1'b1, 10'd7, 32'hAAAA_AAAA, 32'h0000_0006};
        vecs[6]  = '{32'd7, 32'h5555_5555, 1'b1, 1'b0, 10'd0, 32'h0,         32'hAAAA_AAAA};
        vecs[7]  = '{32'd7, 32'h0,         1'b0, 1'b0, 10'd0, 32'h0,         32'h5555_5555};
        vecs[8]  = '{32'd7, 32'h1111_1111, 1'b1, 1'b1, 10'd7, 32'h2222_2222, 32'h5555_5555};
        vecs[9]  = '{32'd7, 32'h0,         1'b0, 1'b0, 10'd0, 32'h0,         32'h2222_2222};
        vecs[10] = '{MM_ST, 32'h0,         1'b0, 1'b0, 10'd0, 32'h0,         32'h0000_0002};
        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].addr, vecs[i].wdata, vecs[i].wr);
            load_en = vecs[i].ld; load_addr = vecs[i].ld_addr; load_data = vecs[i].ld_data;
            cycle();
            check($sformatf("vec%0d_data", i), data, vecs[i].exp);
        end
        load_en = 1'b0;

        // FIFO fill with one overflowing byte, then drain
        for (int i = 0; i < 9; i++) begin
            drive(MM_OUT, 32'h41 + 32'(i), 1'b1);
            cycle();
        end
        drive(MM_ST, 32'h0, 1'b0);
        cycle();
        check("fill_status", data, 32'h0000_0809);
        drive(32'd0, 32'h0, 1'b0);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("drain%0d_valid", i), 32'(out_valid), 32'h1);
            check($sformatf("drain%0d_byte", i), 32'(out_data), 32'h41 + 32'(i));
            cycle();
        end
        check("drained_valid", 32'(out_valid), 32'h0);
        drive(MM_ST, 32'h0, 1'b0);
        cycle();
        check("drained_status", data, 32'h0000_000A);
        drive(MM_ST, 32'hFFFF_FFFF, 1'b1);
        cycle();
        drive(MM_ST, 32'h0, 1'b0);
        cycle();
        check("status_cleared", data, 32'h0000_0002);

        // Push and pop together while full
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive(MM_OUT, 32'h60 + 32'(i), 1'b1);
            cycle();
        end
        out_ready = 1'b1;
        drive(MM_OUT, 32'h5A, 1'b1);
        cycle();
        out_ready = 1'b0;
        drive(MM_ST, 32'h0, 1'b0);
        cycle();
        check("pushpop_status", data, 32'h0000_0801);
        for (int i = 0; i < 7; i++) exp_seq[i] = 8'h61 + 8'(i);
        exp_seq[7] = 8'h5A;
        drive(32'd0, 32'h0, 1'b0);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("pushpop%0d_byte", i), 32'(out_data), 32'(exp_seq[i]));
            cycle();
        end
        check("pushpop_empty", 32'(out_valid), 32'h0);
        out_ready = 1'b0;

        // Cycle counter: consecutive reads, clear by write, forced wrap
        drive(MM_CYC, 32'h0, 1'b0);
        cycle();
        d1 = data;
        cycle();
        d2 = data;
        check("cycles_step", d2, d1 + 32'd1);
        drive(MM_CYC, 32'h1234, 1'b1);
        cycle();
        drive(MM_CYC, 32'h0, 1'b0);
        cycle();
        check("cycles_clear0", data, 32'h0);
        cycle();
        check("cycles_clear1", data, 32'h1);
        m_cyc_ok = 0;
        force dut.cycles = 32'hFFFF_FFFF;
        cycle();
        check("cycles_forced", data, 32'hFFFF_FFFF);
        release dut.cycles;
        got = 0;
        for (int k = 0; k < 3 && !got; k++) begin
            cycle();
            if (data !== 32'hFFFF_FFFF) begin
                got = 1;
                check("cycles_wrap", data, 32'h0);
            end
        end
        if (!got) check("cycles_wrap_timeout", data, 32'h0);
        cycle();
        check("cycles_after_wrap", data, 32'h1);
        drive(MM_CYC, 32'h0, 1'b1);
        cycle();

        // Reset with queued bytes and sticky set; all write sources active during reset
        for (int i = 0; i < 3; i++) begin
            drive(MM_OUT, 32'hC0 + 32'(i), 1'b1);
            cycle();
        end
        drive(UNMAP, 32'h0, 1'b0);
        cycle();
        reset = 1'b1;
        drive(32'd5, 32'hDEAD_DEAD, 1'b1);
        load_en = 1'b1; load_addr = 10'd5; load_data = 32'hBEEF_BEEF;
        out_ready = 1'b1;
        cycle();
        reset = 1'b0; load_en = 1'b0; out_ready = 1'b0;
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_data", data, 32'h0);
        drive(MM_CYC, 32'h0, 1'b0);
        cycle();
        check("rst_cycles", data, 32'h0);
        drive(MM_ST, 32'h0, 1'b0);
        cycle();
        check("rst_status", data, 32'h0000_0002);
        drive(32'd5, 32'h0, 1'b0);
        cycle();
        check("rst_ram_kept", data, 32'h1234_5678);

        // Randomized traffic against the model
        for (int i = 0; i < 16; i++) begin
            load_en = 1'b1; load_addr = 10'(i); load_data = $urandom;
            drive(32'd0, 32'h0, 1'b0);
            cycle();
        end
        load_en = 1'b0;
        for (int n = 0; n < 1500; n++) begin
            case ($urandom_range(0, 7))
                0, 1, 2, 3: address = 32'($urandom_range(0, 15));
                4:          address = MM_OUT;
                5:          address = MM_ST;
                6:          address = MM_CYC;
                default:    address = ($urandom_range(0, 1) != 0) ? UNMAP : MM_BAD;
            endcase
            datao     = $urandom;
            rw        = ($urandom_range(0, 2) == 0);
            out_ready = ($urandom_range(0, 3) == 0);
            load_en   = ($urandom_range(0, 7) == 0);
            load_addr = 10'($urandom_range(0, 15));
            load_data = $urandom;
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
